my_intf_rx: RTL and testbench
=============================

Name: my_intf_rx

Overview:
- Receiving end of the single-bit `out` interface driven by my_module's capture flop chain.
- Resynchronizes the line and deframes it (start bit, DATA_W data bits LSB-first, stop bit, one bit per clk).
- Presents each word on a valid/ready handshake with a single-entry output register.
- Flags framing errors and overruns for the interface timing/ECO sign-off benches.

Parameters:
- DATA_W, 8, data bits per frame (1..32)
- SYNC_STAGES, 2, capture/synchronizer flops ahead of the FSM (>=1)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_bit  input  1  serial line from upstream `out`; idle level 1
- rx_data  output  DATA_W  received word, stable while rx_valid=1
- rx_valid  output  1  word available
- rx_ready  input  1  consumer accepts word when rx_valid&rx_ready at edge
- frame_err  output  1  one-cycle pulse: stop bit sampled 0
- overrun  output  1  one-cycle pulse: completed word dropped because output register still full
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset: async clear. Sync flops = 1, state = IDLE, rx_data = 0, rx_valid = 0, frame_err = 0, overrun = 0, busy = 0. Assertion mid-frame discards the partial word. Deassertion is released on the next clk edge.
- Sync chain: the FSM sees `s = in_bit` delayed SYNC_STAGES edges. Edge 0 is the first capture of a bit into stage 1. The FSM acts on that bit at edge SYNC_STAGES.
- States:
  - IDLE: s=0 -> DATA, bit_cnt=0; else stay.
  - DATA: shift s into shreg[bit_cnt] (LSB first), bit_cnt++. Go to STOP after DATA_W bits.
  - STOP: if s=1, the word completes and the next state is IDLE. If s=0, pulse frame_err, drop the word, go to BREAK.
  - BREAK: wait for s=1 -> IDLE. A line held low is never taken as a new start.
- Latency: start bit captured at edge 0 -> rx_valid=1 after edge SYNC_STAGES+DATA_W+1 (11 for defaults). The same edge loads rx_data.
- Back-to-back frames: a start bit immediately following a stop bit is accepted, giving a full word every DATA_W+2 cycles.
- Output register, at a word-complete edge:
  - if rx_valid=0, or rx_valid&rx_ready, load rx_data and set rx_valid=1.
  - otherwise (rx_valid=1 & !rx_ready), keep the old word and pulse overrun.
- Handshake without a completion: rx_valid&rx_ready clears rx_valid. rx_data holds its last value.
- Simultaneous events: accept and load in the same cycle means rx_valid stays 1 and no overrun. frame_err and overrun are mutually exclusive per cycle.
- bit_cnt width is $clog2(DATA_W+1) and does not wrap past DATA_W. Unused states return to IDLE.
- No combinational path from in_bit to any output. All outputs are registered.

Decomposition:
- Package my_intf_pkg:
  - state enum {IDLE, DATA, STOP, BREAK}
  - LINE_IDLE=1'b1
  - START_LVL=1'b0
  - STOP_LVL=1'b1
- Sub-module my_sync_chain (SYNC_STAGES, reset value 1), reused for other single-bit interface captures.
- The FSM, shift register and output register stay in my_intf_rx.

Test Plan:
- Reset then line idle 1 for 20 cycles -> rx_valid=0, busy=0, no pulses.
- Frame 0xA5 (bits 0,1,0,1,0,0,1,0,1,1) with rx_ready=1 -> rx_valid=1 after edge 11, rx_data=8'hA5, cleared next edge.
- Frames 0x3C then 0xC3 back-to-back, rx_ready=0 throughout -> rx_data=8'h3C kept, overrun pulses once at the second completion. Raising rx_ready the same cycle as the second completion instead gives rx_data=8'hC3, no overrun.
- Frame 0xFF with stop bit 0, line held low 5 more cycles then 1 -> frame_err one pulse, rx_valid stays 0, no new start until line returns to 1. The next frame 0x01 is received correctly.
- rst pulsed after 4 data bits of a frame -> all outputs 0 immediately (async). The remaining line bits with line idle do not produce a word. A following clean frame 0x5A is received.
- DATA_W=16, SYNC_STAGES=3: frame 0xBEEF -> rx_data=16'hBEEF, rx_valid rises after edge 20.

Source files
------------

// File: rtl/my_intf_pkg.sv
// Shared types and line levels for the single-bit serial interface receiver.
package my_intf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STOP  = 2'd2,
    BREAK = 2'd3
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/my_sync_chain.sv
// Single-bit capture/synchronizer chain; output is the input delayed SYNC_STAGES edges.
module my_sync_chain #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= {SYNC_STAGES{RST_VAL}};
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/my_intf_rx.sv
// Deframes the resynchronized serial line (start, DATA_W bits LSB-first, stop)
// into a single-entry valid/ready output register with framing/overrun pulses.
module my_intf_rx
  import my_intf_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_bit,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic              s;
  state_t            state, state_next;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic [DATA_W-1:0] rx_data_next;
  logic              rx_valid_next, frame_err_next, overrun_next, busy_next;
  logic              word_done_c;

  my_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (LINE_IDLE)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (in_bit),
    .q  (s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      shreg     <= shreg_next;
      rx_data   <= rx_data_next;
      rx_valid  <= rx_valid_next;
      frame_err <= frame_err_next;
      overrun   <= overrun_next;
      busy      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    shreg_next     = shreg;
    word_done_c    = 1'b0;
    frame_err_next = 1'b0;
    overrun_next   = 1'b0;
    rx_data_next   = rx_data;
    rx_valid_next  = rx_valid;

    case (state)
      IDLE: begin
        if (s == START_LVL) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        for (int i = 0; i < int'(DATA_W); i++) begin
          if (bit_cnt == CNT_W'(i)) shreg_next[i] = s;
        end
        bit_cnt_next = bit_cnt + CNT_W'(1);
        if (bit_cnt == CNT_W'(DATA_W - 1)) state_next = STOP;
      end
      STOP: begin
        if (s == STOP_LVL) begin
          word_done_c = 1'b1;
          state_next  = IDLE;
        end else begin
          frame_err_next = 1'b1;
          state_next     = BREAK;
        end
      end
      // A line held low after a bad stop bit must return high before any new start.
      BREAK: begin
        if (s == LINE_IDLE) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Output register: handshake drains, completion loads or reports overrun.
    if (rx_valid && rx_ready) rx_valid_next = 1'b0;
    if (word_done_c) begin
      if (!rx_valid || rx_ready) begin
        rx_data_next  = shreg;
        rx_valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end

    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_my_intf_rx.sv
// Bench for my_intf_rx: scoreboard of expected words plus table-driven frames and timing sequences.
module tb_my_intf_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_bit, rx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_err, overrun, busy;
  logic        in_bit2, rx_ready2;
  logic [15:0] rx_data2;
  logic        rx_valid2, frame_err2, overrun2, busy2;

  always #5 clk = ~clk;

  my_intf_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  my_intf_rx #(.DATA_W(16), .SYNC_STAGES(3)) dut2 (
    .clk(clk), .rst(rst), .in_bit(in_bit2), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .rx_ready(rx_ready2), .frame_err(frame_err2), .overrun(overrun2), .busy(busy2)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         err_cnt = 0;
  int         ovr_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sb_exp;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put_bit(input bit sel, input logic b);
    @(posedge clk);
    #2;
    if (sel) in_bit2 = b;
    else     in_bit  = b;
  endtask

  task automatic send_frame(input bit sel, input int w, input logic [31:0] d, input logic stop);
    logic [31:0] dv;
    dv = d;
    put_bit(sel, 1'b0);
    for (int i = 0; i < w; i++) put_bit(sel, dv[i]);
    put_bit(sel, stop);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      in_bit  = 1'b1;
      in_bit2 = 1'b1;
    end
  endtask

  // Scoreboard: every accepted word must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) err_cnt++;
      if (overrun) ovr_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got word %0h expected none", rx_data);
        end else begin
          sb_exp = exp_q.pop_front();
          check("sb_word", 32'(rx_data), 32'(sb_exp));
        end
      end
    end
  end

  initial begin
    int e0, o0;
    vecs[0] = '{8'h00, 1'b1, 0};
    vecs[1] = '{8'hFF, 1'b0, 1};
    vecs[2] = '{8'h01, 1'b1, 0};
    vecs[3] = '{8'h80, 1'b1, 0};
    vecs[4] = '{8'h96, 1'b1, 0};

    rst = 1'b1; in_bit = 1'b1; in_bit2 = 1'b1; rx_ready = 1'b0; rx_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Reset state and idle line.
    idle(20);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("idle_pulses", 32'(err_cnt + ovr_cnt), 32'd0);

    // 0xA5 latency: valid after edge 11, cleared the next edge.
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    fork
      send_frame(1'b0, 8, 32'hA5, 1'b1);
      begin
        repeat (12) @(posedge clk);
        @(negedge clk); check("lat_pre", 32'(rx_valid), 32'd0);
        @(negedge clk); check("lat_valid", 32'(rx_valid), 32'd1);
        check("lat_data", 32'(rx_data), 32'hA5);
        @(negedge clk); check("lat_clear", 32'(rx_valid), 32'd0);
      end
    join
    idle(4);

    // Table-driven frames with consumer always ready.
    foreach (vecs[i]) begin
      e0 = err_cnt;
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(1'b0, 8, 32'(vecs[i].data), vecs[i].stop);
      if (!vecs[i].stop) begin
        repeat (5) put_bit(1'b0, 1'b0);
        check($sformatf("vec%0d_break_busy", i), 32'(busy), 32'd1);
      end
      idle(8);
      check($sformatf("vec%0d_err", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_valid", i), 32'(rx_valid), 32'd0);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
      check($sformatf("vec%0d_q", i), 32'(exp_q.size()), 32'd0);
    end

    // Back-to-back 0x3C, 0xC3 with consumer stalled: second word overruns.
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    exp_q.push_back(8'h3C);
    send_frame(1'b0, 8, 32'h3C, 1'b1);
    send_frame(1'b0, 8, 32'hC3, 1'b1);
    idle(6);
    check("ovr_pulse", 32'(ovr_cnt - o0), 32'd1);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_hold", 32'(rx_data), 32'h3C);
    rx_ready = 1'b1;
    idle(3);
    check("ovr_drain", 32'(rx_valid), 32'd0);
    check("ovr_q", 32'(exp_q.size()), 32'd0);

    // Same pair, ready raised exactly for the second completion edge.
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    fork
      begin
        send_frame(1'b0, 8, 32'h3C, 1'b1);
        send_frame(1'b0, 8, 32'hC3, 1'b1);
      end
      begin
        repeat (22) @(posedge clk);
        #2 rx_ready = 1'b1;
      end
    join
    idle(4);
    check("same_ovr", 32'(ovr_cnt - o0), 32'd0);
    check("same_data", 32'(rx_data), 32'hC3);
    check("same_valid", 32'(rx_valid), 32'd0);
    check("same_q", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame after 4 data bits.
    put_bit(1'b0, 1'b0);
    put_bit(1'b0, 1'b1);
    put_bit(1'b0, 1'b0);
    put_bit(1'b0, 1'b1);
    put_bit(1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(rx_valid), 32'd0);
    check("arst_data", 32'(rx_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_pulses", 32'({frame_err, overrun}), 32'd0);
    in_bit = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    idle(15);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_valid", 32'(rx_valid), 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(1'b0, 8, 32'h5A, 1'b1);
    idle(8);
    check("post_rst_q", 32'(exp_q.size()), 32'd0);

    // Wide instance: 16 data bits, 3 sync stages, valid after edge 20.
    rx_ready2 = 1'b1;
    fork
      send_frame(1'b1, 16, 32'hBEEF, 1'b1);
      begin
        repeat (21) @(posedge clk);
        @(negedge clk); check("w16_pre", 32'(rx_valid2), 32'd0);
        @(negedge clk); check("w16_valid", 32'(rx_valid2), 32'd1);
        check("w16_data", 32'(rx_data2), 32'hBEEF);
        @(negedge clk); check("w16_clear", 32'(rx_valid2), 32'd0);
      end
    join
    idle(4);
    check("w16_busy", 32'(busy2), 32'd0);

    check("total_err", 32'(err_cnt), 32'd1);
    check("total_ovr", 32'(ovr_cnt), 32'd1);
    check("final_q", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
